cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Shares the two common data buses (CDB, CDB2) among NUM_REQ result producers (ALU, branch RS, load/store).
//  Each producer deposits a finished {ROB tag, data} into a private one-entry holding slot.
//  Each cycle, up to two occupied slots are picked round-robin and broadcast on CDB/CDB2.
//  Outputs feed the CDBiscast/CDBrobNum/CDBdata(2) inputs of every RS and the ROB.
// PARAMETERS
//  NUM_REQ      4          number of producers / holding slots (2..8)
//  TAG_W        6          ROB tag width
//  DATA_W       32         result data width
//  INVALID_TAG  6'b010000  "no tag" encoding; never broadcast
// PORTS
//  clock        in   1                 single clock; all state updates on posedge
//  reset        in   1                 asynchronous, active-low reset
//  flush        in   1                 synchronous squash (mispredict): drop all pending results
//  req_valid    in   NUM_REQ           producer i offers a result this cycle
//  req_tag      in   NUM_REQ*TAG_W     tag of producer i, slice [i*TAG_W +: TAG_W]
//  req_data     in   NUM_REQ*DATA_W    data of producer i, slice [i*DATA_W +: DATA_W]
//  req_ready    out  NUM_REQ           slot i empty; offer is accepted at this edge
//  CDBiscast    out  1                 bus 1 valid, one-cycle pulse per broadcast
//  CDBrobNum    out  TAG_W             bus 1 tag
//  CDBdata      out  DATA_W            bus 1 data
//  CDBiscast2   out  1                 bus 2 valid
//  CDBrobNum2   out  TAG_W             bus 2 tag
//  CDBdata2     out  DATA_W            bus 2 data
//  pending_cnt  out  4                 number of occupied slots (registered)
// BEHAVIOUR
//  Reset (reset=0, async): all slots empty; rr_ptr=0; CDBiscast/CDBiscast2=0; tags=INVALID_TAG; data=0;
//   pending_cnt=0; req_ready all 1. Release is taken at the next posedge.
//  Accept: at posedge, if req_valid[i] && req_ready[i] && req_tag[i]!=INVALID_TAG, slot i <= {tag,data}.
//   An offer with INVALID_TAG is ignored. An offer to a full slot is ignored; the producer holds it.
//  req_ready[i] = !slot_valid[i], combinational from state only. No bypass: a slot granted at edge k
//   can accept again from edge k+1.
//  Pick (from state at start of cycle): scan i = rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   The first occupied slot goes to bus 1; the second occupied slot goes to bus 2.
//  Grant at posedge: bus regs load the picked entries, iscast=1, picked slots cleared.
//   With one occupant, only bus 1 fires; CDBiscast2=0, CDBrobNum2=INVALID_TAG.
//   With none, both iscast=0 and both tags=INVALID_TAG. Data holds its last value.
//   The same slot never appears on both buses.
//  rr_ptr <= (index of last granted slot + 1) mod NUM_REQ. It is unchanged when nothing is granted.
//  Latency: result accepted at edge k is broadcast at edge k+1 at earliest, visible for one cycle.
//  Fairness: an occupied slot is broadcast within ceil(NUM_REQ/2) cycles.
//  flush=1 at edge: all slots cleared, no grants this edge (iscast=0, tags=INVALID_TAG),
//   offers this edge dropped, rr_ptr held. Flush wins over accept and grant.
//  Reset asserted mid-broadcast: outputs drop asynchronously to their reset values.
//  pending_cnt = occupied slots after the edge's accept/grant/flush updates.
// STRUCTURE
//  Shared package cpu_defs: TAG_W, DATA_W, INVALID_TAG (6'b010000), CDB bus struct/field widths.
//  Sub-module rr_pick2: combinational. Inputs occ[NUM_REQ], ptr. Outputs g1_vld/g1_idx/g2_vld/g2_idx.
//  Top holds the slot array, rr_ptr, bus registers and counter.
// TESTING
//  1 Reset, idle 5 cycles -> iscast both 0, tags 6'b010000, req_ready=4'b1111, pending_cnt=0.
//  2 Slot0 offered tag 3, data 0xA at edge k -> CDBiscast=1, CDBrobNum=3, CDBdata=0xA after edge k+1
//    only; CDBiscast2=0.
//  3 All four offer tags 1..4 same edge, rr_ptr=0 -> next cycle bus1=1, bus2=2; following cycle
//    bus1=3, bus2=4; then both idle; rr_ptr returns to 0.
//  4 Slot2 refilled every cycle while slots 0,1,3 also full -> every slot is broadcast within 2
//    cycles; no slot is granted twice before all others.
//  5 Three slots full, flush=1 with a new offer on slot1 -> no broadcast, pending_cnt=0,
//    req_ready=4'b1111, rr_ptr unchanged.
//  6 Offer with tag 6'b010000 -> not accepted, nothing broadcast. Reset asserted while iscast=1
//    -> iscast 0 immediately, no clock edge needed.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: default widths, the "no tag" encoding and the broadcast bus payload.
package cdb_arbiter_pkg;

    localparam int unsigned CDB_TAG_W  = 6;
    localparam int unsigned CDB_DATA_W = 32;
    localparam logic [CDB_TAG_W-1:0] CDB_INVALID_TAG = 6'b010000;

    typedef struct packed {
        logic                  iscast;
        logic [CDB_TAG_W-1:0]  rob_num;
        logic [CDB_DATA_W-1:0] data;
    } cdb_bus_t;

    // Increment modulo n; used to advance the round-robin pointer.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 32'd1 >= n) ? 32'd0 : v + 32'd1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick2.sv
// Round-robin two-winner picker: first and second occupied slot scanning upward from ptr.
module cdb_arbiter_rr_pick2 #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] occ,
    input  logic [PTR_W-1:0]   ptr,
    output logic               g1_vld,
    output logic [PTR_W-1:0]   g1_idx,
    output logic               g2_vld,
    output logic [PTR_W-1:0]   g2_idx
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        g1_vld = 1'b0;
        g1_idx = '0;
        g2_vld = 1'b0;
        g2_idx = '0;
        idx    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((32'(ptr) + k) % NUM_REQ);
            if (occ[idx]) begin
                if (!g1_vld) begin
                    g1_vld = 1'b1;
                    g1_idx = idx;
                end else if (!g2_vld) begin
                    g2_vld = 1'b1;
                    g2_idx = idx;
                end
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Shares the two common data buses among NUM_REQ producers, each with a one-entry holding slot.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned      NUM_REQ     = 4,
    parameter int unsigned      TAG_W       = CDB_TAG_W,
    parameter int unsigned      DATA_W      = CDB_DATA_W,
    parameter logic [TAG_W-1:0] INVALID_TAG = TAG_W'(CDB_INVALID_TAG)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        CDBiscast,
    output logic [TAG_W-1:0]            CDBrobNum,
    output logic [DATA_W-1:0]           CDBdata,
    output logic                        CDBiscast2,
    output logic [TAG_W-1:0]            CDBrobNum2,
    output logic [DATA_W-1:0]           CDBdata2,
    output logic [3:0]                  pending_cnt
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] slot_valid;
    logic [NUM_REQ-1:0] slot_valid_nxt;
    logic [TAG_W-1:0]   slot_tag  [NUM_REQ];
    logic [DATA_W-1:0]  slot_data [NUM_REQ];
    logic [PTR_W-1:0]   rr_ptr;

    logic [NUM_REQ-1:0] accept;
    logic [NUM_REQ-1:0] grant_mask;
    logic [3:0]         cnt_nxt;
    logic               g1_vld;
    logic [PTR_W-1:0]   g1_idx;
    logic               g2_vld;
    logic [PTR_W-1:0]   g2_idx;
    logic [PTR_W-1:0]   last_idx;

    assign req_ready = ~slot_valid;
    assign last_idx  = g2_vld ? g2_idx : g1_idx;

    cdb_arbiter_rr_pick2 #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .occ    (slot_valid),
        .ptr    (rr_ptr),
        .g1_vld (g1_vld),
        .g1_idx (g1_idx),
        .g2_vld (g2_vld),
        .g2_idx (g2_idx)
    );

    // Next slot occupancy: granted slots free up, accepted offers fill empty slots, flush clears all.
    always_comb begin
        accept         = '0;
        grant_mask     = '0;
        slot_valid_nxt = '0;
        cnt_nxt        = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            accept[i] = req_valid[i] && !slot_valid[i] &&
                        (req_tag[i*TAG_W +: TAG_W] != INVALID_TAG);
        end
        if (g1_vld) grant_mask[g1_idx] = 1'b1;
        if (g2_vld) grant_mask[g2_idx] = 1'b1;
        if (!flush) slot_valid_nxt = (slot_valid & ~grant_mask) | accept;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cnt_nxt = cnt_nxt + 4'(slot_valid_nxt[i]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_valid  <= '0;
            rr_ptr      <= '0;
            pending_cnt <= '0;
            CDBiscast   <= 1'b0;
            CDBrobNum   <= INVALID_TAG;
            CDBdata     <= '0;
            CDBiscast2  <= 1'b0;
            CDBrobNum2  <= INVALID_TAG;
            CDBdata2    <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                slot_tag[i]  <= INVALID_TAG;
                slot_data[i] <= '0;
            end
        end else begin
            slot_valid  <= slot_valid_nxt;
            pending_cnt <= cnt_nxt;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (accept[i] && !flush) begin
                    slot_tag[i]  <= req_tag[i*TAG_W +: TAG_W];
                    slot_data[i] <= req_data[i*DATA_W +: DATA_W];
                end
            end
            if (flush) begin
                CDBiscast  <= 1'b0;
                CDBrobNum  <= INVALID_TAG;
                CDBiscast2 <= 1'b0;
                CDBrobNum2 <= INVALID_TAG;
            end else begin
                CDBiscast  <= g1_vld;
                CDBrobNum  <= g1_vld ? slot_tag[g1_idx] : INVALID_TAG;
                CDBiscast2 <= g2_vld;
                CDBrobNum2 <= g2_vld ? slot_tag[g2_idx] : INVALID_TAG;
                if (g1_vld) CDBdata  <= slot_data[g1_idx];
                if (g2_vld) CDBdata2 <= slot_data[g2_idx];
                if (g1_vld) rr_ptr <= PTR_W'(wrap_inc(32'(last_idx), NUM_REQ));
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with a per-edge scoreboard of expected bus contents.
module tb_cdb_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned TW = 6;
    localparam int unsigned DW = 32;
    localparam logic [TW-1:0] INV = 6'b010000;

    logic              clock = 1'b0;
    logic              reset;
    logic              flush;
    logic [N-1:0]      req_valid;
    logic [N*TW-1:0]   req_tag;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              CDBiscast;
    logic [TW-1:0]     CDBrobNum;
    logic [DW-1:0]     CDBdata;
    logic              CDBiscast2;
    logic [TW-1:0]     CDBrobNum2;
    logic [DW-1:0]     CDBdata2;
    logic [3:0]        pending_cnt;

    typedef struct {
        logic          v1;
        logic [TW-1:0] t1;
        logic [DW-1:0] d1;
        logic          v2;
        logic [TW-1:0] t2;
        logic [DW-1:0] d2;
        logic [3:0]    cnt;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    cdb_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_tag     (req_tag),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .CDBiscast   (CDBiscast),
        .CDBrobNum   (CDBrobNum),
        .CDBdata     (CDBdata),
        .CDBiscast2  (CDBiscast2),
        .CDBrobNum2  (CDBrobNum2),
        .CDBdata2    (CDBdata2),
        .pending_cnt (pending_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_bus(input logic v1, input logic [TW-1:0] t1, input logic [DW-1:0] d1,
                              input logic v2, input logic [TW-1:0] t2, input logic [DW-1:0] d2,
                              input logic [3:0] cnt);
        exp_t e;
        e.v1 = v1; e.t1 = t1; e.d1 = d1;
        e.v2 = v2; e.t2 = t2; e.d2 = d2;
        e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic expect_idle(input logic [3:0] cnt);
        expect_bus(1'b0, INV, '0, 1'b0, INV, '0, cnt);
    endtask

    // Advance one edge, sample 1 time unit later, compare against the oldest expectation.
    task automatic step(input string name);
        exp_t e;
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            check({name, ".sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check({name, ".iscast"},  64'(CDBiscast),   64'(e.v1));
            check({name, ".robnum"},  64'(CDBrobNum),   64'(e.t1));
            check({name, ".iscast2"}, 64'(CDBiscast2),  64'(e.v2));
            check({name, ".robnum2"}, 64'(CDBrobNum2),  64'(e.t2));
            check({name, ".pending"}, 64'(pending_cnt), 64'(e.cnt));
            if (e.v1) check({name, ".data"},  64'(CDBdata),  64'(e.d1));
            if (e.v2) check({name, ".data2"}, 64'(CDBdata2), 64'(e.d2));
        end
    endtask

    task automatic offer(input int unsigned i, input logic [TW-1:0] tag, input logic [DW-1:0] data);
        req_valid[i]          = 1'b1;
        req_tag[i*TW +: TW]   = tag;
        req_data[i*DW +: DW]  = data;
    endtask

    task automatic clr_offers();
        req_valid = '0;
        req_tag   = '0;
        req_data  = '0;
    endtask

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        clr_offers();
        #12;
        check("rst.iscast",  64'(CDBiscast),   64'd0);
        check("rst.robnum",  64'(CDBrobNum),   64'(INV));
        check("rst.iscast2", 64'(CDBiscast2),  64'd0);
        check("rst.robnum2", 64'(CDBrobNum2),  64'(INV));
        check("rst.ready",   64'(req_ready),   64'hF);
        check("rst.pending", 64'(pending_cnt), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // Idle after reset
        for (int c = 0; c < 5; c++) begin
            expect_idle(4'd0);
            step("idle");
        end
        check("idle.ready", 64'(req_ready), 64'hF);

        // Single result on slot 0: accepted at edge k, broadcast at k+1 only
        offer(0, 6'd3, 32'hA);
        expect_idle(4'd1);
        step("single.acc");
        check("single.ready", 64'(req_ready), 64'hE);
        clr_offers();
        expect_bus(1'b1, 6'd3, 32'hA, 1'b0, INV, '0, 4'd0);
        step("single.bc");
        expect_idle(4'd0);
        step("single.after");

        // Slot 3 alone, bringing the pointer back to 0
        offer(3, 6'd9, 32'h99);
        expect_idle(4'd1);
        step("wrap.acc");
        clr_offers();
        expect_bus(1'b1, 6'd9, 32'h99, 1'b0, INV, '0, 4'd0);
        step("wrap.bc");

        // All four at once, pointer 0
        for (int unsigned i = 0; i < N; i++) offer(i, TW'(i + 1), DW'(32'h100 + i + 1));
        expect_idle(4'd4);
        step("all.acc");
        clr_offers();
        expect_bus(1'b1, 6'd1, 32'h101, 1'b1, 6'd2, 32'h102, 4'd2);
        step("all.bc1");
        expect_bus(1'b1, 6'd3, 32'h103, 1'b1, 6'd4, 32'h104, 4'd0);
        step("all.bc2");
        expect_idle(4'd0);
        step("all.idle");

        // Pointer back at 0: slot 0 must lead slot 3
        offer(3, 6'd7, 32'h77);
        offer(0, 6'd5, 32'h55);
        expect_idle(4'd2);
        step("ptr0.acc");
        clr_offers();
        expect_bus(1'b1, 6'd5, 32'h55, 1'b1, 6'd7, 32'h77, 4'd0);
        step("ptr0.bc");

        // Slot 2 offering every cycle while 0,1,3 are full
        for (int unsigned i = 0; i < N; i++) offer(i, TW'(10 + i), DW'(32'h200 + i));
        expect_idle(4'd4);
        step("fair.acc");
        clr_offers();
        offer(2, 6'd20, 32'h220);
        expect_bus(1'b1, 6'd10, 32'h200, 1'b1, 6'd11, 32'h201, 4'd2);
        step("fair.bc1");
        expect_bus(1'b1, 6'd12, 32'h202, 1'b1, 6'd13, 32'h203, 4'd0);
        step("fair.bc2");
        expect_idle(4'd1);
        step("fair.refill");
        clr_offers();
        expect_bus(1'b1, 6'd20, 32'h220, 1'b0, INV, '0, 4'd0);
        step("fair.bc3");

        // Flush with three slots full (pointer is 3)
        offer(0, 6'd30, 32'h300);
        offer(1, 6'd31, 32'h301);
        offer(3, 6'd33, 32'h303);
        expect_idle(4'd3);
        step("flush.fill");
        clr_offers();
        flush = 1'b1;
        offer(1, 6'd41, 32'h401);
        offer(2, 6'd42, 32'h402);
        expect_idle(4'd0);
        step("flush.edge");
        flush = 1'b0;
        clr_offers();
        check("flush.ready", 64'(req_ready), 64'hF);
        expect_idle(4'd0);
        step("flush.after");

        // Pointer held at 3: slot 3 leads slot 1
        offer(1, 6'd35, 32'h351);
        offer(3, 6'd36, 32'h363);
        expect_idle(4'd2);
        step("ptr3.acc");
        clr_offers();
        expect_bus(1'b1, 6'd36, 32'h363, 1'b1, 6'd35, 32'h351, 4'd0);
        step("ptr3.bc");

        // Invalid tag is never accepted
        offer(0, INV, 32'h5A5A);
        expect_idle(4'd0);
        step("inv.edge");
        check("inv.ready", 64'(req_ready), 64'hF);
        clr_offers();
        expect_idle(4'd0);
        step("inv.after");

        // Reset while a broadcast is on the bus drops outputs without a clock edge
        offer(0, 6'd40, 32'hBEEF);
        expect_idle(4'd1);
        step("arst.acc");
        clr_offers();
        expect_bus(1'b1, 6'd40, 32'hBEEF, 1'b0, INV, '0, 4'd0);
        step("arst.bc");
        #1 reset = 1'b0;
        #1;
        check("arst.iscast", 64'(CDBiscast), 64'd0);
        check("arst.robnum", 64'(CDBrobNum), 64'(INV));
        check("arst.data",   64'(CDBdata),   64'd0);
        check("arst.ready",  64'(req_ready), 64'hF);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);

        check("sb.leftover", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
